bram_frame_reader: RTL



---
 rtl/bram_pkg.sv | 16 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/bram_frame_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and helpers for the frame BRAM reader
// Purpose: reader FSM state encoding and the frame word-count helper.
// Ports: none (package).
package bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

    function automatic int frame_words(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
// Purpose: small prefetch buffer; head shows the oldest entry while not empty.
// Ports: clk, reset (async, active-high), push/push_data, pop,
//        head (oldest entry), full, empty, count (occupancy).
module sync_fifo #(
    parameter int data_width = 8,
    parameter int depth      = 4,
    localparam int cnt_bits  = $clog2(depth + 1),
    localparam int ptr_bits  = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output logic [data_width-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [cnt_bits-1:0]   count
);

    logic [data_width-1:0] mem [depth];
    logic [ptr_bits-1:0]   wr_ptr;
    logic [ptr_bits-1:0]   rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == cnt_bits'(depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [ptr_bits-1:0] ptr_next(input logic [ptr_bits-1:0] p);
        return (p == ptr_bits'(depth - 1)) ? '0 : p + ptr_bits'(1);
    endfunction

    // Storage is not reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + cnt_bits'(do_push) - cnt_bits'(do_pop);
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// rtl/bram_frame_reader.sv - reads one frame from a BRAM half and streams it out
// Purpose: on start, issues frame_size sequential reads from the selected BRAM
//          half, tracks the fixed read latency, buffers returned words in a
//          prefetch FIFO and presents them as split a/b fields with a last flag.
// Ports: clk, reset (async, active-high), start, bram_index_in, idle,
//        rd_bram_index/rd_address/rd_ena/rd_data (BRAM read port),
//        out_a/out_b/out_valid/out_ready/out_last (output stream).
module bram_frame_reader
    import bram_pkg::*;
#(
    parameter int width      = 120,
    parameter int height     = 240,
    parameter int frame_size = frame_words(width, height),
    parameter int addr_bits  = $clog2(frame_size),
    parameter int a_width    = 13,
    parameter int b_width    = 8,
    parameter int rd_latency = 2,
    parameter int fifo_depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         bram_index_in,
    output logic                         idle,
    output logic                         rd_bram_index,
    output logic [addr_bits-1:0]         rd_address,
    output logic                         rd_ena,
    input  logic [a_width+b_width-1:0]   rd_data,
    output logic [a_width-1:0]           out_a,
    output logic [b_width-1:0]           out_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int data_width = a_width + b_width;
    localparam int cnt_bits   = $clog2(fifo_depth + 1);
    localparam int out_bits   = $clog2(rd_latency + 1);
    localparam logic [addr_bits-1:0] last_addr = addr_bits'(frame_size - 1);

    reader_state_t          state;
    logic [rd_latency-1:0]  valid_sr;
    logic [rd_latency-1:0]  last_sr;
    logic [out_bits-1:0]    outstanding;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [cnt_bits-1:0]    fifo_count;
    logic [data_width:0]    fifo_head;
    logic                   issue_ok;
    logic                   drain_done;

    // Credit check: every read in flight already owns a FIFO slot, so a push
    // can never land in a full FIFO. Occupancy is taken before this cycle's pop.
    assign issue_ok = (state == ST_ISSUE) &&
                      ((int'(outstanding) + int'(fifo_count)) < fifo_depth);
    assign rd_ena   = issue_ok;
    assign idle     = (state == ST_IDLE);

    assign fifo_push = valid_sr[rd_latency-1] && !fifo_full;
    assign fifo_pop  = out_valid && out_ready;

    assign out_valid = !fifo_empty;
    assign out_last  = !fifo_empty && fifo_head[data_width];
    assign out_a     = fifo_head[data_width-1:b_width];
    assign out_b     = fifo_head[b_width-1:0];

    // Nothing in flight means nothing can be pushed, so the FIFO is drained
    // once it is empty or its final entry is leaving this cycle.
    assign drain_done = (outstanding == '0) &&
                        (fifo_empty || ((fifo_count == cnt_bits'(1)) && fifo_pop));

    sync_fifo #(
        .data_width (data_width + 1),
        .depth      (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({last_sr[rd_latency-1], rd_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read-latency tracking: clearing these on reset discards in-flight data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_sr    <= '0;
            last_sr     <= '0;
            outstanding <= '0;
        end else begin
            valid_sr[0] <= rd_ena;
            last_sr[0]  <= rd_ena && (rd_address == last_addr);
            for (int k = 1; k < rd_latency; k++) begin
                valid_sr[k] <= valid_sr[k-1];
                last_sr[k]  <= last_sr[k-1];
            end
            outstanding <= outstanding + out_bits'(rd_ena)
                                       - out_bits'(valid_sr[rd_latency-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            rd_address    <= '0;
            rd_bram_index <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rd_bram_index <= bram_index_in;
                        rd_address    <= '0;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ok) begin
                        if (rd_address == last_addr) begin
                            rd_address <= '0;
                            state      <= ST_DRAIN;
                        end else begin
                            rd_address <= rd_address + addr_bits'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
